lsu_writeback_seq: RTL and testbench
====================================

// Module: lsu_writeback_seq
// PURPOSE
// - Downstream of the load/store unit. Tracks one in-flight memory op (rd, kind, address) from issue to retire.
// - Writes returned load data into the 16-bit register-file write port as two half-word writes, low half first.
// - Raises access-fault traps on LSU error or response timeout.
// - Drives a load-use hazard flag back to decode.
// PARAMETERS
// TIMEOUT_CYCLES  64  WAIT-state cycles with no LSU response before trapping; 0 disables the timeout
// PORTS
// clk            in   1   clock
// rst_n          in   1   asynchronous active-low reset
// issue_i        in   1   op launched this cycle (same cycle as LSU start); honoured only when issue_ready_o=1
// issue_load_i   in   1   1=load, 0=store
// issue_rd_i     in   5   destination register (ignored for stores)
// issue_addr_i   in   32  effective address, kept for trap value
// issue_ready_o  out  1   new op may be issued this cycle
// lsu_valid_i    in   1   LSU data-valid: low half in cycle 1, high half in cycle 2
// lsu_err_i      in   1   LSU bus error
// lsu_ldata_i    in   16  LSU load data half
// src1_i, src2_i in   5   decode source registers, used for hazard check
// hazard_o       out  1   decode must stall
// rf_we_o        out  1   register-file write enable
// rf_waddr_o     out  5   register-file write address
// rf_whalf_o     out  1   0=bits[15:0], 1=bits[31:16]
// rf_wdata_o     out  16  register-file write data
// done_o         out  1   op retired (one-cycle pulse)
// trap_o         out  1   access fault (one-cycle pulse)
// trap_cause_o   out  4   5=load access fault, 7=store access fault
// trap_tval_o    out  32  faulting address
// BEHAVIOUR
// - Reset (async): state=WB_IDLE, timeout counter=0, latched rd/kind/addr=0.
//   All outputs 0, except issue_ready_o=1. Reset mid-op drops any pending half-write; no trap is raised.
// - States: WB_IDLE, WB_WAIT, WB_HI. All RF, done and trap outputs are combinational from state + LSU inputs.
// - WB_IDLE: issue_ready_o=1. issue_i latches rd/load/addr, clears the counter, and goes to WB_WAIT. LSU inputs are ignored.
// - WB_WAIT: issue_ready_o=0. Priority order, highest first:
//   1. lsu_err_i=1: trap_o=1, cause 5 for a load or 7 for a store, tval=latched addr, no RF write; next state WB_IDLE.
//   2. lsu_valid_i=1: for a load with rd!=0, rf_we_o=1, waddr=rd, whalf=0, wdata=lsu_ldata_i; next state WB_HI.
//   3. Counter reaches TIMEOUT_CYCLES-1 (TIMEOUT_CYCLES!=0): same trap as lsu_err_i; next state WB_IDLE.
//   4. Otherwise the counter increments, saturating.
// - WB_HI: always exactly one cycle; the LSU guarantees the second valid beat.
//   For a load with rd!=0: rf_we_o=1, whalf=1, wdata=lsu_ldata_i. done_o=1. lsu_err_i is ignored.
//   issue_ready_o=1, so back-to-back ops are allowed: issue_i latches the new op and goes to WB_WAIT; otherwise WB_IDLE.
// - Stores: no RF writes. done_o pulses in WB_HI.
// - x0 destination: the load completes normally, rf_we_o stays 0 in both halves.
// - hazard_o = (state!=WB_IDLE) & load & rd!=0 & (src1_i==rd | src2_i==rd).
//   Stays high through WB_HI, because the upper half is not written until the end of that cycle.
// - Latency: issue -> low-half write = LSU latency; low -> high half = 1 cycle; done_o coincides with the high-half write.
// - Simultaneous trap and issue is impossible: issue_ready_o=0 in WB_WAIT.
// STRUCTURE
// - Shared package typedefs: enum wb_state_e {WB_IDLE, WB_WAIT, WB_HI}.
// - Shared package constants: CAUSE_LOAD_ACCESS_FAULT=4'd5, CAUSE_STORE_ACCESS_FAULT=4'd7.
// - One sub-module: lsu_timeout_ctr, a saturating counter with clear/enable and an expired flag; tied off when TIMEOUT_CYCLES=0.
// TESTING
// 1. Load rd=5, addr=0x100; LSU returns 0x1234 then 0xABCD
//    -> RF writes (5,half0,0x1234) then (5,half1,0xABCD); done_o with the second write; hazard_o for src1=5 until done.
// 2. Store addr=0x200; two valid beats
//    -> rf_we_o stays 0; done_o one pulse on the second beat; issue_ready_o=0 while in WAIT.
// 3. Load addr=0x304, lsu_err_i on the 3rd WAIT cycle
//    -> trap_o=1, cause=5, tval=0x304, no RF write; next cycle issue_ready_o=1.
// 4. TIMEOUT_CYCLES=4; store addr=0x40 with no LSU response
//    -> trap_o on the 4th WAIT cycle, cause=7, tval=0x40.
// 5. Load rd=0 followed back-to-back by load rd=7 issued in the WB_HI cycle
//    -> no writes for rd=0; second op enters WAIT with no idle gap; rd=7 halves written.
// 6. rst_n asserted between the low and high writes of a load
//    -> all outputs reset immediately; no high-half write, trap or done afterwards.

Source files
------------

// File: rtl/lsu_writeback_seq_pkg.sv
// Shared types and constants for the LSU writeback sequencer.
// Contents:
//   wb_state_e      - sequencer states (idle, waiting for LSU, high-half beat)
//   CAUSE_*         - access-fault trap cause codes
//   fault_cause()   - selects the access-fault cause for a load or a store
package lsu_writeback_seq_pkg;

  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_WAIT = 2'd1,
    WB_HI   = 2'd2
  } wb_state_e;

  localparam logic [3:0] CAUSE_LOAD_ACCESS_FAULT  = 4'd5;
  localparam logic [3:0] CAUSE_STORE_ACCESS_FAULT = 4'd7;

  function automatic logic [3:0] fault_cause(input logic is_load);
    return is_load ? CAUSE_LOAD_ACCESS_FAULT : CAUSE_STORE_ACCESS_FAULT;
  endfunction

endpackage

// File: rtl/lsu_writeback_seq_if.sv
// Bundle of all handshake/bus signals around the LSU writeback sequencer.
// Modports:
//   slave  - the sequencer: receives issue, LSU response and decode sources;
//            drives issue_ready, hazard, register-file write port, done and trap.
//   master - the surrounding pipeline (or a testbench), opposite directions.
interface lsu_writeback_seq_if;
  logic        issue_i;
  logic        issue_load_i;
  logic [4:0]  issue_rd_i;
  logic [31:0] issue_addr_i;
  logic        issue_ready_o;
  logic        lsu_valid_i;
  logic        lsu_err_i;
  logic [15:0] lsu_ldata_i;
  logic [4:0]  src1_i;
  logic [4:0]  src2_i;
  logic        hazard_o;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic        rf_whalf_o;
  logic [15:0] rf_wdata_o;
  logic        done_o;
  logic        trap_o;
  logic [3:0]  trap_cause_o;
  logic [31:0] trap_tval_o;

  modport slave (
    input  issue_i, issue_load_i, issue_rd_i, issue_addr_i,
    input  lsu_valid_i, lsu_err_i, lsu_ldata_i, src1_i, src2_i,
    output issue_ready_o, hazard_o, rf_we_o, rf_waddr_o, rf_whalf_o, rf_wdata_o,
    output done_o, trap_o, trap_cause_o, trap_tval_o
  );

  modport master (
    output issue_i, issue_load_i, issue_rd_i, issue_addr_i,
    output lsu_valid_i, lsu_err_i, lsu_ldata_i, src1_i, src2_i,
    input  issue_ready_o, hazard_o, rf_we_o, rf_waddr_o, rf_whalf_o, rf_wdata_o,
    input  done_o, trap_o, trap_cause_o, trap_tval_o
  );
endinterface

// File: rtl/lsu_writeback_seq_timeout_ctr.sv
// lsu_timeout_ctr: saturating cycle counter for the LSU response timeout.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   clr        - restart counting from zero (wins over en)
//   en         - count one more idle cycle; holds once LIMIT-1 is reached
//   expired    - counter currently holds LIMIT-1
// LIMIT must be at least 1; the parent omits this block when the timeout is disabled.
module lsu_timeout_ctr #(
  parameter int unsigned LIMIT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned    CW   = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0]  LAST = CW'(LIMIT - 1);
  localparam logic [CW-1:0]  ONE  = CW'(1);
  localparam logic [CW-1:0]  ZERO = CW'(0);

  logic [CW-1:0] count_r;

  // Count enabled cycles since the last clear, stopping at LAST.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= ZERO;
    end else if (clr) begin
      count_r <= ZERO;
    end else if (en && (count_r != LAST)) begin
      count_r <= count_r + ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == LAST);

endmodule

// File: rtl/lsu_writeback_seq.sv
// lsu_writeback_seq: tracks one in-flight load/store from issue to retire.
// Load data returns as two 16-bit beats and is written to the register file
// low half first; an LSU error or a response timeout raises an access-fault
// trap; a load-use hazard flag is driven back to decode.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - lsu_writeback_seq_if.slave (issue, LSU response, decode
//                sources, RF write port, done/trap)
// Parameter TIMEOUT_CYCLES: WAIT cycles without response before trapping
// (0 disables the timeout).
module lsu_writeback_seq
  import lsu_writeback_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  lsu_writeback_seq_if.slave  bus
);

  wb_state_e   state_r;
  wb_state_e   next_state_s;
  logic        load_r;
  logic [4:0]  rd_r;
  logic [31:0] addr_r;

  logic        issue_ready_s;
  logic        issue_take_s;
  logic        writes_rf_s;
  logic        ctr_en_s;
  logic        expired_s;
  logic        hazard_s;
  logic        rf_we_s;
  logic [4:0]  rf_waddr_s;
  logic        rf_whalf_s;
  logic [15:0] rf_wdata_s;
  logic        done_s;
  logic        trap_s;
  logic [3:0]  trap_cause_s;
  logic [31:0] trap_tval_s;

  // Loads to x0 still sequence normally but never touch the register file.
  assign writes_rf_s  = load_r && (rd_r != 5'd0);
  assign issue_take_s = issue_ready_s && bus.issue_i;

  // Next state and all combinational outputs from state + LSU inputs.
  always_comb begin
    next_state_s  = state_r;
    issue_ready_s = 1'b0;
    ctr_en_s      = 1'b0;
    rf_we_s       = 1'b0;
    rf_waddr_s    = 5'd0;
    rf_whalf_s    = 1'b0;
    rf_wdata_s    = 16'd0;
    done_s        = 1'b0;
    trap_s        = 1'b0;
    trap_cause_s  = 4'd0;
    trap_tval_s   = 32'd0;
    case (state_r)
      WB_IDLE: begin
        issue_ready_s = 1'b1;
        if (bus.issue_i) begin
          next_state_s = WB_WAIT;
        end else begin
          next_state_s = WB_IDLE;
        end
      end
      WB_WAIT: begin
        if (bus.lsu_err_i) begin
          trap_s       = 1'b1;
          trap_cause_s = fault_cause(load_r);
          trap_tval_s  = addr_r;
          next_state_s = WB_IDLE;
        end else if (bus.lsu_valid_i) begin
          if (writes_rf_s) begin
            rf_we_s    = 1'b1;
            rf_waddr_s = rd_r;
            rf_wdata_s = bus.lsu_ldata_i;
          end else begin
            rf_we_s    = 1'b0;
          end
          next_state_s = WB_HI;
        end else if (expired_s) begin
          trap_s       = 1'b1;
          trap_cause_s = fault_cause(load_r);
          trap_tval_s  = addr_r;
          next_state_s = WB_IDLE;
        end else begin
          ctr_en_s     = 1'b1;
          next_state_s = WB_WAIT;
        end
      end
      WB_HI: begin
        // The LSU guarantees the second beat here, so errors are not sampled.
        issue_ready_s = 1'b1;
        done_s        = 1'b1;
        if (writes_rf_s) begin
          rf_we_s    = 1'b1;
          rf_waddr_s = rd_r;
          rf_whalf_s = 1'b1;
          rf_wdata_s = bus.lsu_ldata_i;
        end else begin
          rf_we_s    = 1'b0;
        end
        if (bus.issue_i) begin
          next_state_s = WB_WAIT;
        end else begin
          next_state_s = WB_IDLE;
        end
      end
      default: begin
        next_state_s = WB_IDLE;
      end
    endcase
  end

  // Held through WB_HI: the upper half lands only at the end of that cycle.
  assign hazard_s = (state_r != WB_IDLE) && writes_rf_s &&
                    ((bus.src1_i == rd_r) || (bus.src2_i == rd_r));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= WB_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Capture the op descriptor when an issue is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_r <= 1'b0;
      rd_r   <= 5'd0;
      addr_r <= 32'd0;
    end else if (issue_take_s) begin
      load_r <= bus.issue_load_i;
      rd_r   <= bus.issue_rd_i;
      addr_r <= bus.issue_addr_i;
    end else begin
      load_r <= load_r;
      rd_r   <= rd_r;
      addr_r <= addr_r;
    end
  end

  generate
    if (TIMEOUT_CYCLES != 0) begin : g_timeout
      lsu_timeout_ctr #(
        .LIMIT   (TIMEOUT_CYCLES)
      ) u_timeout_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (issue_take_s),
        .en      (ctr_en_s),
        .expired (expired_s)
      );
    end else begin : g_no_timeout
      assign expired_s = 1'b0;
    end
  endgenerate

  assign bus.issue_ready_o = issue_ready_s;
  assign bus.hazard_o      = hazard_s;
  assign bus.rf_we_o       = rf_we_s;
  assign bus.rf_waddr_o    = rf_waddr_s;
  assign bus.rf_whalf_o    = rf_whalf_s;
  assign bus.rf_wdata_o    = rf_wdata_s;
  assign bus.done_o        = done_s;
  assign bus.trap_o        = trap_s;
  assign bus.trap_cause_o  = trap_cause_s;
  assign bus.trap_tval_o   = trap_tval_s;

endmodule

// File: tb/tb_lsu_writeback_seq.sv
// Testbench for lsu_writeback_seq: two instances (timeout 64 and 4) share one
// stimulus stream. Directed vector table, hand-written reset/timeout
// sequences, then randomized traffic checked against a transaction model.
module tb_lsu_writeback_seq;

  typedef struct packed {
    logic        issue;
    logic        load;
    logic [4:0]  rd;
    logic [31:0] addr;
    logic        valid;
    logic        err;
    logic [15:0] ldata;
    logic [4:0]  src1;
    logic [4:0]  src2;
  } in_t;

  typedef struct packed {
    logic        ready;
    logic        hazard;
    logic        we;
    logic [4:0]  waddr;
    logic        whalf;
    logic [15:0] wdata;
    logic        done;
    logic        trap;
    logic [3:0]  cause;
    logic [31:0] tval;
  } out_t;

  typedef struct packed {
    in_t  in;
    out_t exp;
  } vec_t;

  // Transaction-level view of the op in flight.
  typedef struct {
    bit          busy;
    bit          low_done;
    bit          load;
    logic [4:0]  rd;
    logic [31:0] addr;
    int unsigned waits;
  } mdl_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  in_t  cur;
  vec_t vecs [21];
  out_t idle_o;

  lsu_writeback_seq_if if_a ();
  lsu_writeback_seq_if if_b ();

  assign if_b.issue_i      = if_a.issue_i;
  assign if_b.issue_load_i = if_a.issue_load_i;
  assign if_b.issue_rd_i   = if_a.issue_rd_i;
  assign if_b.issue_addr_i = if_a.issue_addr_i;
  assign if_b.lsu_valid_i  = if_a.lsu_valid_i;
  assign if_b.lsu_err_i    = if_a.lsu_err_i;
  assign if_b.lsu_ldata_i  = if_a.lsu_ldata_i;
  assign if_b.src1_i       = if_a.src1_i;
  assign if_b.src2_i       = if_a.src2_i;

  lsu_writeback_seq #(.TIMEOUT_CYCLES(64)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
  lsu_writeback_seq #(.TIMEOUT_CYCLES(4))  dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic in_t mi(input logic iss, input logic ld, input logic [4:0] rd,
                             input logic [31:0] addr, input logic v, input logic e,
                             input logic [15:0] d, input logic [4:0] s1, input logic [4:0] s2);
    in_t x;
    x.issue = iss; x.load = ld; x.rd = rd; x.addr = addr; x.valid = v;
    x.err = e; x.ldata = d; x.src1 = s1; x.src2 = s2;
    return x;
  endfunction

  function automatic out_t mo(input logic rdy, input logic hz, input logic we,
                              input logic [4:0] wa, input logic wh, input logic [15:0] wd,
                              input logic dn, input logic tr, input logic [3:0] c,
                              input logic [31:0] tv);
    out_t o;
    o.ready = rdy; o.hazard = hz; o.we = we; o.waddr = wa; o.whalf = wh;
    o.wdata = wd; o.done = dn; o.trap = tr; o.cause = c; o.tval = tv;
    return o;
  endfunction

  function automatic out_t get_out(input bit sel_b);
    out_t o;
    if (sel_b) begin
      o = mo(if_b.issue_ready_o, if_b.hazard_o, if_b.rf_we_o, if_b.rf_waddr_o,
             if_b.rf_whalf_o, if_b.rf_wdata_o, if_b.done_o, if_b.trap_o,
             if_b.trap_cause_o, if_b.trap_tval_o);
    end else begin
      o = mo(if_a.issue_ready_o, if_a.hazard_o, if_a.rf_we_o, if_a.rf_waddr_o,
             if_a.rf_whalf_o, if_a.rf_wdata_o, if_a.done_o, if_a.trap_o,
             if_a.trap_cause_o, if_a.trap_tval_o);
    end
    return o;
  endfunction

  function automatic out_t mdl_out(input mdl_t m, input in_t x, input int unsigned tmo);
    out_t o;
    bit   wr;
    o  = '0;
    wr = m.load && (m.rd != 5'd0);
    o.ready  = !m.busy || m.low_done;
    o.hazard = m.busy && wr && ((x.src1 == m.rd) || (x.src2 == m.rd));
    if (m.busy && !m.low_done) begin
      if (x.err || (!x.valid && tmo != 0 && m.waits == tmo - 1)) begin
        o.trap  = 1'b1;
        o.cause = m.load ? 4'd5 : 4'd7;
        o.tval  = m.addr;
      end else if (x.valid && wr) begin
        o.we = 1'b1; o.waddr = m.rd; o.whalf = 1'b0; o.wdata = x.ldata;
      end
    end else if (m.busy) begin
      o.done = 1'b1;
      if (wr) begin
        o.we = 1'b1; o.waddr = m.rd; o.whalf = 1'b1; o.wdata = x.ldata;
      end
    end
    return o;
  endfunction

  function automatic mdl_t mdl_next(input mdl_t m, input in_t x, input int unsigned tmo);
    mdl_t n;
    n = m;
    if (!m.busy || m.low_done) begin
      n.busy = 1'b0;
      n.low_done = 1'b0;
      if (x.issue) begin
        n.busy = 1'b1; n.load = x.load; n.rd = x.rd; n.addr = x.addr; n.waits = 0;
      end
    end else if (x.err) begin
      n.busy = 1'b0;
    end else if (x.valid) begin
      n.low_done = 1'b1;
    end else if (tmo != 0 && m.waits == tmo - 1) begin
      n.busy = 1'b0;
    end else begin
      n.waits = m.waits + 1;
    end
    return n;
  endfunction

  task automatic apply(input in_t x);
    cur               = x;
    if_a.issue_i      = x.issue;
    if_a.issue_load_i = x.load;
    if_a.issue_rd_i   = x.rd;
    if_a.issue_addr_i = x.addr;
    if_a.lsu_valid_i  = x.valid;
    if_a.lsu_err_i    = x.err;
    if_a.lsu_ldata_i  = x.ldata;
    if_a.src1_i       = x.src1;
    if_a.src2_i       = x.src2;
  endtask

  task automatic chk(input string name, input out_t act, input out_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got rdy=%b hz=%b we=%b wa=%0d wh=%b wd=%h dn=%b tr=%b c=%0d tv=%h, expected rdy=%b hz=%b we=%b wa=%0d wh=%b wd=%h dn=%b tr=%b c=%0d tv=%h",
               name, act.ready, act.hazard, act.we, act.waddr, act.whalf, act.wdata, act.done,
               act.trap, act.cause, act.tval, exp.ready, exp.hazard, exp.we, exp.waddr,
               exp.whalf, exp.wdata, exp.done, exp.trap, exp.cause, exp.tval);
    end
  endtask

  // Reset both instances and check the reset output values.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    apply('0);
    #1;
    chk("reset_a", get_out(1'b0), idle_o);
    chk("reset_b", get_out(1'b1), idle_o);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    mdl_t ma;
    mdl_t mb;
    in_t  r;
    n_checks = 0;
    n_fail   = 0;
    idle_o   = mo(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 16'h0, 1'b0, 1'b0, 4'd0, 32'h0);
    rst_n    = 1'b0;
    apply('0);

    // Load rd=5 / store / load error / x0 load back-to-back with rd=7.
    vecs[0]  = '{mi(1,1,5,32'h100,0,0,16'h0,5,0),    idle_o};
    vecs[1]  = '{mi(0,0,0,32'h0,0,0,16'h0,5,0),      mo(0,1,0,0,0,16'h0,0,0,0,32'h0)};
    vecs[2]  = '{mi(0,0,0,32'h0,1,0,16'h1234,5,0),   mo(0,1,1,5,0,16'h1234,0,0,0,32'h0)};
    vecs[3]  = '{mi(0,0,0,32'h0,1,0,16'hABCD,5,0),   mo(1,1,1,5,1,16'hABCD,1,0,0,32'h0)};
    vecs[4]  = '{mi(0,0,0,32'h0,0,0,16'h0,5,0),      idle_o};
    vecs[5]  = '{mi(1,0,3,32'h200,0,0,16'h0,3,0),    idle_o};
    vecs[6]  = '{mi(0,0,0,32'h0,1,0,16'h1111,3,0),   mo(0,0,0,0,0,16'h0,0,0,0,32'h0)};
    vecs[7]  = '{mi(0,0,0,32'h0,1,0,16'h2222,3,0),   mo(1,0,0,0,0,16'h0,1,0,0,32'h0)};
    vecs[8]  = '{mi(0,0,0,32'h0,0,0,16'h0,3,0),      idle_o};
    vecs[9]  = '{mi(1,1,9,32'h304,0,0,16'h0,0,9),    idle_o};
    vecs[10] = '{mi(0,0,0,32'h0,0,0,16'h0,0,9),      mo(0,1,0,0,0,16'h0,0,0,0,32'h0)};
    vecs[11] = '{mi(0,0,0,32'h0,0,0,16'h0,0,9),      mo(0,1,0,0,0,16'h0,0,0,0,32'h0)};
    vecs[12] = '{mi(0,0,0,32'h0,0,1,16'h0,0,9),      mo(0,1,0,0,0,16'h0,0,1,5,32'h304)};
    vecs[13] = '{mi(0,0,0,32'h0,0,0,16'h0,0,9),      idle_o};
    vecs[14] = '{mi(1,1,0,32'h10,0,0,16'h0,0,0),     idle_o};
    vecs[15] = '{mi(0,0,0,32'h0,1,0,16'h5555,0,0),   mo(0,0,0,0,0,16'h0,0,0,0,32'h0)};
    vecs[16] = '{mi(1,1,7,32'h20,1,0,16'h6666,7,0),  mo(1,0,0,0,0,16'h0,1,0,0,32'h0)};
    vecs[17] = '{mi(1,1,2,32'h999,0,0,16'h0,7,2),    mo(0,1,0,0,0,16'h0,0,0,0,32'h0)};
    vecs[18] = '{mi(0,0,0,32'h0,1,0,16'h7777,7,0),   mo(0,1,1,7,0,16'h7777,0,0,0,32'h0)};
    vecs[19] = '{mi(0,0,0,32'h0,1,1,16'h8888,7,0),   mo(1,1,1,7,1,16'h8888,1,0,0,32'h0)};
    vecs[20] = '{mi(0,0,0,32'h0,0,0,16'h0,7,0),      idle_o};

    do_reset();
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      apply(vecs[i].in);
      #1;
      chk($sformatf("vec%0d", i), get_out(1'b0), vecs[i].exp);
    end

    // Reset between the low and high half of a load.
    do_reset();
    @(negedge clk); apply(mi(1,1,5,32'h100,0,0,16'h0,5,0));
    @(negedge clk); apply(mi(0,0,0,32'h0,1,0,16'hCAFE,5,0));
    #1; chk("rst_lo", get_out(1'b0), mo(0,1,1,5,0,16'hCAFE,0,0,0,32'h0));
    @(negedge clk); apply(mi(0,0,0,32'h0,1,0,16'hBEEF,5,0));
    #1; chk("rst_hi_pre", get_out(1'b0), mo(1,1,1,5,1,16'hBEEF,1,0,0,32'h0));
    rst_n = 1'b0;
    #1; chk("rst_mid", get_out(1'b0), idle_o);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); apply(mi(0,0,0,32'h0,1,0,16'hBEEF,5,0));
      #1; chk($sformatf("rst_after%0d", i), get_out(1'b0), idle_o);
    end

    // Store with no response on the TIMEOUT_CYCLES=4 instance.
    do_reset();
    @(negedge clk); apply(mi(1,0,0,32'h40,0,0,16'h0,0,0));
    #1; chk("tmo_issue", get_out(1'b1), idle_o);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk); apply('0);
      #1; chk($sformatf("tmo_wait%0d", i), get_out(1'b1), mo(0,0,0,0,0,16'h0,0,0,0,32'h0));
    end
    @(negedge clk); apply('0);
    #1; chk("tmo_trap", get_out(1'b1), mo(0,0,0,0,0,16'h0,0,1,7,32'h40));
    @(negedge clk); apply('0);
    #1; chk("tmo_after", get_out(1'b1), idle_o);

    // Randomized traffic against the model, then a low-response phase for timeouts.
    do_reset();
    ma = '{default: 0};
    mb = '{default: 0};
    for (int i = 0; i < 3000; i++) begin
      int unsigned pv;
      pv = (i < 1500) ? 30 : 1;
      @(negedge clk);
      r.issue = ($urandom_range(0, 99) < 60);
      r.load  = $urandom_range(0, 1);
      r.rd    = 5'($urandom_range(0, 7));
      r.addr  = $urandom;
      r.valid = ($urandom_range(0, 99) < pv);
      r.err   = ($urandom_range(0, 99) < 2);
      r.ldata = 16'($urandom);
      r.src1  = 5'($urandom_range(0, 7));
      r.src2  = 5'($urandom_range(0, 7));
      apply(r);
      #1;
      chk($sformatf("rand_a%0d", i), get_out(1'b0), mdl_out(ma, cur, 64));
      chk($sformatf("rand_b%0d", i), get_out(1'b1), mdl_out(mb, cur, 4));
      ma = mdl_next(ma, cur, 64);
      mb = mdl_next(mb, cur, 4);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
